// File: rtl/panda_mc_ctrl.sv
// Multi-cycle control sequencer for the Panda core: walks one instruction through
// fetch, decode, execute, memory and writeback, driving bus handshakes and write strobes.
module panda_mc_ctrl #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             instr_req_o,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  output logic             ir_we_o,
  input  logic             rd_we_i,
  input  logic             load_i,
  input  logic             store_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             illegal_i,
  input  logic             alu_cmp_i,
  output logic             data_req_o,
  output logic             data_we_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic             halt_o,
  output logic             err_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IF_REQ,
    S_IF_WAIT,
    S_ID,
    S_EX,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic [CNT_W-1:0]  r_instr_cnt;
  logic              w_retire;
  logic              w_in_wait;
  logic              w_exit;
  logic              w_run;

  // Strobes are suppressed while reset is held so an aborted handshake never fires.
  assign w_run = ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IF_REQ;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_err      <= w_err_nxt;
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    w_err_nxt      = r_err;
    w_retire       = 1'b0;
    w_in_wait      = 1'b0;
    w_exit         = 1'b0;
    case (r_state)
      S_IF_REQ: begin
        w_in_wait = 1'b1;
        w_exit    = instr_gnt_i;
        if (instr_gnt_i) begin
          w_state_nxt = S_IF_WAIT;
        end
      end
      S_IF_WAIT: begin
        w_in_wait = 1'b1;
        w_exit    = instr_rvalid_i;
        if (instr_rvalid_i) begin
          w_state_nxt = S_ID;
        end
      end
      S_ID: begin
        w_state_nxt = illegal_i ? S_HALT : S_EX;
      end
      S_EX: begin
        w_state_nxt = (load_i | store_i) ? S_MEM_REQ : S_WB;
      end
      S_MEM_REQ: begin
        w_in_wait = 1'b1;
        w_exit    = data_gnt_i;
        if (data_gnt_i) begin
          w_state_nxt = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        w_in_wait = 1'b1;
        w_exit    = data_rvalid_i;
        if (data_rvalid_i) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_retire    = 1'b1;
        w_state_nxt = S_IF_REQ;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IF_REQ;
      end
    endcase

    // A handshake that completes on its last allowed cycle still wins over the timeout.
    if (w_in_wait && !w_exit) begin
      if (r_wait_cnt == WAIT_LAST) begin
        w_state_nxt = S_HALT;
        w_err_nxt   = 1'b1;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
      end
    end
  end

  always_comb begin
    instr_req_o = 1'b0;
    ir_we_o     = 1'b0;
    data_req_o  = 1'b0;
    data_we_o   = 1'b0;
    rf_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 1'b0;
    if (w_run) begin
      case (r_state)
        S_IF_REQ: begin
          instr_req_o = 1'b1;
        end
        S_IF_WAIT: begin
          ir_we_o = instr_rvalid_i;
        end
        S_MEM_REQ: begin
          data_req_o = 1'b1;
          data_we_o  = store_i;
        end
        S_WB: begin
          rf_we_o  = rd_we_i & ~store_i & ~branch_i;
          pc_we_o  = 1'b1;
          pc_sel_o = jump_i | (branch_i & alu_cmp_i);
        end
        default: begin
        end
      endcase
    end
  end

  assign halt_o      = (r_state == S_HALT);
  assign err_o       = r_err;
  assign instr_cnt_o = r_instr_cnt;

endmodule

// File: tb/tb_panda_mc_ctrl.sv
// Scoreboard bench for panda_mc_ctrl: open-loop bus/decoder stimulus from per-instruction
// plans, expected per-cycle outputs derived from the instruction timeline and queued.
module tb_panda_mc_ctrl;

  localparam int TB_CNT_W = 4;
  localparam int TO       = 4;

  logic                clk;
  logic                rst_i;
  logic                instr_req_o;
  logic                instr_gnt_i;
  logic                instr_rvalid_i;
  logic                ir_we_o;
  logic                rd_we_i;
  logic                load_i;
  logic                store_i;
  logic                branch_i;
  logic                jump_i;
  logic                illegal_i;
  logic                alu_cmp_i;
  logic                data_req_o;
  logic                data_we_o;
  logic                data_gnt_i;
  logic                data_rvalid_i;
  logic                rf_we_o;
  logic                pc_we_o;
  logic                pc_sel_o;
  logic                halt_o;
  logic                err_o;
  logic [TB_CNT_W-1:0] instr_cnt_o;

  panda_mc_ctrl #(
    .CNT_W          (TB_CNT_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .ir_we_o        (ir_we_o),
    .rd_we_i        (rd_we_i),
    .load_i         (load_i),
    .store_i        (store_i),
    .branch_i       (branch_i),
    .jump_i         (jump_i),
    .illegal_i      (illegal_i),
    .alu_cmp_i      (alu_cmp_i),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .rf_we_o        (rf_we_o),
    .pc_we_o        (pc_we_o),
    .pc_sel_o       (pc_sel_o),
    .halt_o         (halt_o),
    .err_o          (err_o),
    .instr_cnt_o    (instr_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strb = {instr_req, ir_we, data_req, data_we, rf_we, pc_we, pc_sel}
  typedef struct packed {
    bit                chk_st;
    bit [6:0]          strb;
    bit                halt;
    bit                err;
    bit [TB_CNT_W-1:0] cnt;
  } exp_t;

  // tp: 0 none, 1 fetch grant, 2 fetch data, 3 data grant, 4 data response never arrive
  typedef struct packed {
    int fg;
    int fr;
    int mg;
    int mr;
    bit rd_we;
    bit load;
    bit store;
    bit branch;
    bit jump;
    bit cmp;
    bit illegal;
    int tp;
    int rst_at;
    bit stale;
  } plan_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk_exp(input bit chk, input bit [6:0] s, input bit h, input bit e);
    exp_t x;
    x.chk_st = chk;
    x.strb   = s;
    x.halt   = h;
    x.err    = e;
    x.cnt    = TB_CNT_W'(m_cnt);
    return x;
  endfunction

  function automatic plan_t mk(input int fg, input int fr, input int mg, input int mr,
                               input bit [6:0] dec, input int tp);
    plan_t p;
    p.fg = fg;
    p.fr = fr;
    p.mg = mg;
    p.mr = mr;
    {p.rd_we, p.load, p.store, p.branch, p.jump, p.cmp, p.illegal} = dec;
    p.tp     = tp;
    p.rst_at = -1;
    p.stale  = 1'b0;
    return p;
  endfunction

  function automatic plan_t rand_plan(input bit allow_stop);
    plan_t p;
    int    r;
    p = mk(int'($urandom_range(0, TO - 1)), int'($urandom_range(1, TO)),
           int'($urandom_range(0, TO - 1)), int'($urandom_range(1, TO)),
           7'($urandom) & 7'b1111110, 0);
    if (allow_stop) begin
      p.illegal = ($urandom_range(0, 15) == 0);
      r = int'($urandom_range(0, 19));
      if (r == 0) p.tp = 1;
      else if (r == 1) p.tp = 2;
      else if (r == 2 && (p.load | p.store)) p.tp = 3;
      else if (r == 3 && (p.load | p.store)) p.tp = 4;
      if (p.tp >= 3) p.illegal = 1'b0;
      if ($urandom_range(0, 9) == 0) p.rst_at = int'($urandom_range(0, 12));
    end
    return p;
  endfunction

  task automatic rand_inputs();
    {rd_we_i, load_i, store_i, branch_i, jump_i, illegal_i, alu_cmp_i} = 7'($urandom);
    {instr_gnt_i, instr_rvalid_i, data_gnt_i, data_rvalid_i} = 4'($urandom);
  endtask

  task automatic do_reset(input int n);
    m_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_i = 1'b1;
      rand_inputs();
      q.push_back(mk_exp(i > 0, 7'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic run_plan(input plan_t p);
    int       w, e, wb, hk, last, req_end, dlo, dhi;
    bit       mem, to_err, spi, spd;
    bit [6:0] s;
    mem = p.load | p.store;
    w = -1; e = -1; wb = -1; hk = -1; dlo = -1; dhi = -2; to_err = 1'b0;
    if (p.tp == 1) begin
      req_end = TO - 1; hk = TO; to_err = 1'b1;
    end else begin
      req_end = p.fg;
      if (p.tp == 2) begin
        hk = p.fg + 1 + TO; to_err = 1'b1;
      end else begin
        w = p.fg + p.fr;
        if (p.illegal) hk = w + 2;
        else if (!mem) wb = w + 3;
        else begin
          e = w + 3; dlo = e;
          if (p.tp == 3) begin
            dhi = e + TO - 1; hk = e + TO; to_err = 1'b1;
          end else begin
            dhi = e + p.mg;
            if (p.tp == 4) begin
              hk = e + p.mg + 1 + TO; to_err = 1'b1;
            end else wb = e + p.mg + p.mr + 1;
          end
        end
      end
    end
    last = (wb >= 0) ? wb : hk - 1;

    for (int k = 0; k <= last; k++) begin
      if (k == p.rst_at) begin
        do_reset(1 + int'($urandom_range(0, 1)));
        return;
      end
      @(posedge clk); #1;
      rst_i = 1'b0;
      spi = ($urandom_range(0, 3) == 0);
      spd = ($urandom_range(0, 3) == 0);
      if (w >= 0 && k > w)
        {rd_we_i, load_i, store_i, branch_i, jump_i, illegal_i, alu_cmp_i} =
          {p.rd_we, p.load, p.store, p.branch, p.jump, p.illegal, p.cmp};
      else
        {rd_we_i, load_i, store_i, branch_i, jump_i, illegal_i, alu_cmp_i} = 7'($urandom);
      instr_gnt_i    = (p.tp != 1) && (k == p.fg);
      instr_rvalid_i = (k == w) || (spi && w >= 0 && k > w);
      data_gnt_i     = (dlo >= 0) && (p.tp != 3) && (k == dhi);
      data_rvalid_i  = (wb >= 0 && mem && k == wb - 1) || (spd && (w < 0 || k <= w + 2)) ||
                       (p.stale && k == 0);
      s    = 7'b0;
      s[6] = (k <= req_end);
      s[5] = (k == w);
      s[4] = (k >= dlo && k <= dhi);
      s[3] = s[4] & p.store;
      if (k == wb) begin
        s[2] = p.rd_we & ~p.store & ~p.branch;
        s[1] = 1'b1;
        s[0] = p.jump | (p.branch & p.cmp);
      end
      q.push_back(mk_exp(1'b1, s, 1'b0, 1'b0));
    end

    if (wb >= 0) begin
      m_cnt = (m_cnt + 1) % (1 << TB_CNT_W);
    end else begin
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        rst_i = 1'b0;
        rand_inputs();
        q.push_back(mk_exp(1'b1, 7'b0, 1'b1, to_err));
      end
      do_reset(1 + int'($urandom_range(0, 2)));
    end
  endtask

  initial begin : monitor
    exp_t     ex;
    bit [6:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        ex  = q.pop_front();
        act = {instr_req_o, ir_we_o, data_req_o, data_we_o, rf_we_o, pc_we_o, pc_sel_o};
        n_chk++;
        if (act !== ex.strb) begin
          n_fail++;
          $display("FAIL strobes cyc=%0d got=%b exp=%b (req,irwe,dreq,dwe,rfwe,pcwe,pcsel)",
                   cyc, act, ex.strb);
        end
        if (ex.chk_st) begin
          n_chk++;
          if ({halt_o, err_o, instr_cnt_o} !== {ex.halt, ex.err, ex.cnt}) begin
            n_fail++;
            $display("FAIL status cyc=%0d got halt=%b err=%b cnt=%0d exp halt=%b err=%b cnt=%0d",
                     cyc, halt_o, err_o, instr_cnt_o, ex.halt, ex.err, ex.cnt);
          end
        end
      end
    end
  end

  initial begin : stimulus
    plan_t p;
    rst_i = 1'b1;
    {instr_gnt_i, instr_rvalid_i, data_gnt_i, data_rvalid_i} = 4'b0;
    {rd_we_i, load_i, store_i, branch_i, jump_i, illegal_i, alu_cmp_i} = 7'b0;
    do_reset(3);

    run_plan(mk(0, 1, 0, 1, 7'b1000000, 0));   // ALU, zero wait
    run_plan(mk(0, 1, 3, 1, 7'b1100000, 0));   // load, data grant after 3
    run_plan(mk(1, 2, 1, 2, 7'b1010000, 0));   // store
    run_plan(mk(0, 1, 0, 1, 7'b1001010, 0));   // branch taken
    run_plan(mk(0, 1, 0, 1, 7'b0001000, 0));   // branch not taken
    run_plan(mk(0, 1, 0, 1, 7'b1000100, 0));   // JAL
    run_plan(mk(3, 4, 3, 4, 7'b1100000, 0));   // maximal legal stalls
    run_plan(mk(0, 1, 0, 1, 7'b1000001, 0));   // illegal
    run_plan(mk(0, 1, 0, 1, 7'b1000000, 1));   // fetch grant never comes
    run_plan(mk(2, 1, 0, 1, 7'b1000000, 2));
    run_plan(mk(0, 1, 0, 1, 7'b0010000, 3));
    run_plan(mk(1, 3, 2, 1, 7'b1100000, 4));
    p = mk(0, 1, 0, 4, 7'b1100000, 0);         // reset lands in the data wait
    p.rst_at = 6;
    run_plan(p);
    p = mk(0, 1, 0, 1, 7'b1000000, 0);
    p.stale = 1'b1;
    run_plan(p);

    for (int i = 0; i < 20; i++) run_plan(rand_plan(1'b0));
    for (int i = 0; i < 150; i++) run_plan(rand_plan(1'b1));

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
